// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the memory port arbiter slice: bus widths and the
// arbiter FSM state encoding. No ports; imported by the interface, the
// timeout counter and the arbiter top.
package mem_port_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int SEL_W = 4;

  // Byte-lane mask used for every instruction fetch (always a full word).
  localparam logic [SEL_W-1:0] SEL_ALL = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    RESP   = 2'b11
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the two requester ports (IF-stage instruction port, MEM-stage data
// port) and the Wishbone-style external bus into one interface.
//   master modport : the arbiter's view (drives responses and mem_*)
//   slave modport  : the surrounding core/bus view (drives requests, bus acks)
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  // Instruction port
  logic [XLEN-1:0]  iport_addr;
  logic             iport_req;
  logic [XLEN-1:0]  iport_data;
  logic             iport_ready;
  logic             iport_err;

  // Data port
  logic [XLEN-1:0]  dport_addr;
  logic [XLEN-1:0]  dport_wdata;
  logic             dport_we;
  logic [SEL_W-1:0] dport_sel;
  logic             dport_req;
  logic [XLEN-1:0]  dport_rdata;
  logic             dport_ready;
  logic             dport_err;

  // External memory bus
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic             mem_we;
  logic [SEL_W-1:0] mem_sel;
  logic             mem_cyc;
  logic             mem_stb;
  logic [XLEN-1:0]  mem_rdata;
  logic             mem_ack;
  logic             mem_err;

  modport master (
    input  iport_addr, iport_req,
    output iport_data, iport_ready, iport_err,
    input  dport_addr, dport_wdata, dport_we, dport_sel, dport_req,
    output dport_rdata, dport_ready, dport_err,
    output mem_addr, mem_wdata, mem_we, mem_sel, mem_cyc, mem_stb,
    input  mem_rdata, mem_ack, mem_err
  );

  modport slave (
    output iport_addr, iport_req,
    input  iport_data, iport_ready, iport_err,
    output dport_addr, dport_wdata, dport_we, dport_sel, dport_req,
    input  dport_rdata, dport_ready, dport_err,
    input  mem_addr, mem_wdata, mem_we, mem_sel, mem_cyc, mem_stb,
    output mem_rdata, mem_ack, mem_err
  );

endinterface

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter
// Counts cycles of an outstanding bus transaction and flags when the slave has
// been silent for TIMEOUT cycles.
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   clear   in  restart the count (arbiter not busy)
//   enable  in  count this cycle (arbiter waiting on the bus)
//   expired out high during the TIMEOUT-th busy cycle (count == TIMEOUT-1)
module bus_timeout_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // The count starts at zero in the first busy cycle, so expired rises in the
  // TIMEOUT-th busy cycle and the arbiter aborts on the following edge. The
  // counter parks at LAST rather than wrapping in case enable lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single external memory bus between the IF-stage instruction port
// and the MEM-stage data port. Data requests win contention, except that after
// STARVE_LIMIT consecutive contended data grants the instruction port is
// served. Hung transactions are aborted after TIMEOUT cycles with an error.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  master modport of mem_port_arbiter_if (requester ports + memory bus)
// Every output is a register; responses are one-cycle ready/err pulses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state, state_n;
  logic [STARVE_W-1:0] starve_cnt, starve_n;

  logic [XLEN-1:0]  addr_n, wdata_n, idata_n, drdata_n;
  logic [SEL_W-1:0] sel_n;
  logic             we_n, cyc_n;
  logic             iready_n, ierr_n, dready_n, derr_n;

  logic busy, expired, grant_d, grant_i;

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  // Data normally wins; a pending fetch takes the bus once data has been
  // granted STARVE_LIMIT times in a row while the fetch was waiting.
  assign grant_d = bus.dport_req && !(bus.iport_req && (starve_cnt == STARVE_MAX));
  assign grant_i = bus.iport_req && !grant_d;

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy),
    .enable  (busy),
    .expired (expired)
  );

  // State, starvation count and every visible output are registered here from
  // the next-value signals; reset clears all of it so an interrupted
  // transaction never produces a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      starve_cnt      <= '0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_sel     <= '0;
      bus.mem_cyc     <= 1'b0;
      bus.mem_stb     <= 1'b0;
      bus.iport_data  <= '0;
      bus.iport_ready <= 1'b0;
      bus.iport_err   <= 1'b0;
      bus.dport_rdata <= '0;
      bus.dport_ready <= 1'b0;
      bus.dport_err   <= 1'b0;
    end else begin
      state           <= state_n;
      starve_cnt      <= starve_n;
      bus.mem_addr    <= addr_n;
      bus.mem_wdata   <= wdata_n;
      bus.mem_we      <= we_n;
      bus.mem_sel     <= sel_n;
      bus.mem_cyc     <= cyc_n;
      bus.mem_stb     <= cyc_n;
      bus.iport_data  <= idata_n;
      bus.iport_ready <= iready_n;
      bus.iport_err   <= ierr_n;
      bus.dport_rdata <= drdata_n;
      bus.dport_ready <= dready_n;
      bus.dport_err   <= derr_n;
    end
  end

  // Next-state and next-output logic. Bus fields and read data hold by
  // default; response pulses default low so they last exactly the RESP cycle.
  // When ack and err coincide, the err branch is taken and read data is left
  // untouched. RESP never samples requests, which guarantees at least one
  // idle bus cycle between transactions.
  always_comb begin
    state_n  = state;
    starve_n = starve_cnt;
    addr_n   = bus.mem_addr;
    wdata_n  = bus.mem_wdata;
    we_n     = bus.mem_we;
    sel_n    = bus.mem_sel;
    cyc_n    = bus.mem_cyc;
    idata_n  = bus.iport_data;
    drdata_n = bus.dport_rdata;
    iready_n = 1'b0;
    ierr_n   = 1'b0;
    dready_n = 1'b0;
    derr_n   = 1'b0;

    case (state)
      IDLE: begin
        if (grant_d) begin
          addr_n  = bus.dport_addr;
          wdata_n = bus.dport_wdata;
          we_n    = bus.dport_we;
          sel_n   = bus.dport_sel;
          cyc_n   = 1'b1;
          state_n = BUSY_D;
          if (bus.iport_req) begin
            starve_n = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
          end else begin
            starve_n = '0;
          end
        end else if (grant_i) begin
          addr_n   = bus.iport_addr;
          wdata_n  = '0;
          we_n     = 1'b0;
          sel_n    = SEL_ALL;
          cyc_n    = 1'b1;
          state_n  = BUSY_I;
          starve_n = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (bus.mem_err || expired) begin
          cyc_n   = 1'b0;
          state_n = RESP;
          if (state == BUSY_I) ierr_n = 1'b1;
          else                 derr_n = 1'b1;
        end else if (bus.mem_ack) begin
          cyc_n   = 1'b0;
          state_n = RESP;
          if (state == BUSY_I) begin
            idata_n  = bus.mem_rdata;
            iready_n = 1'b1;
          end else begin
            drdata_n = bus.mem_rdata;
            dready_n = 1'b1;
          end
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scoreboard bench for mem_port_arbiter (TIMEOUT = 8,
// STARVE_LIMIT = 4). Stimulus pushes the expected bus transaction and the
// expected response into queues; independent monitors pop and compare when
// the DUT starts a bus cycle or pulses ready/err.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int SL_ACK  = 0;
  localparam int SL_NONE = 1;
  localparam int SL_BOTH = 2;

  typedef struct {
    logic        isData;
    logic        isErr;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
  } bus_t;

  logic clk;
  logic rst;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT      (8),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  resp_t respQ[$];
  bus_t  busQ[$];

  int compared   = 0;
  int mismatched = 0;

  int          slaveMode = SL_ACK;
  logic [31:0] slaveData = '0;
  logic        prevCyc   = 1'b0;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run wedges somewhere unexpected.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic expectBus(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic [3:0] sel);
    bus_t b;
    b.addr  = addr;
    b.wdata = wdata;
    b.we    = we;
    b.sel   = sel;
    busQ.push_back(b);
  endtask

  task automatic expectResp(input logic isData, input logic isErr, input logic [31:0] data);
    resp_t r;
    r.isData = isData;
    r.isErr  = isErr;
    r.data   = data;
    respQ.push_back(r);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_iport_data"},  bus.iport_data, 32'h0);
    checkOutput({tag, "_iport_ready"}, 32'(bus.iport_ready), 32'h0);
    checkOutput({tag, "_iport_err"},   32'(bus.iport_err), 32'h0);
    checkOutput({tag, "_dport_rdata"}, bus.dport_rdata, 32'h0);
    checkOutput({tag, "_dport_ready"}, 32'(bus.dport_ready), 32'h0);
    checkOutput({tag, "_dport_err"},   32'(bus.dport_err), 32'h0);
    checkOutput({tag, "_mem_addr"},    bus.mem_addr, 32'h0);
    checkOutput({tag, "_mem_wdata"},   bus.mem_wdata, 32'h0);
    checkOutput({tag, "_mem_we"},      32'(bus.mem_we), 32'h0);
    checkOutput({tag, "_mem_sel"},     32'(bus.mem_sel), 32'h0);
    checkOutput({tag, "_mem_cyc"},     32'(bus.mem_cyc), 32'h0);
    checkOutput({tag, "_mem_stb"},     32'(bus.mem_stb), 32'h0);
  endtask

  // Issue n back-to-back requests on one port, holding req high between them
  // (addresses step by 4), waiting a bounded time for each response.
  task automatic applyStimulus(input bit isData, input int n, input logic [31:0] base,
                               input logic [31:0] wdata, input logic we, input logic [3:0] sel);
    for (int i = 0; i < n; i++) begin
      int   w    = 0;
      logic seen = 1'b0;
      if (isData) begin
        bus.dport_addr  = base + 32'(i * 4);
        bus.dport_wdata = wdata;
        bus.dport_we    = we;
        bus.dport_sel   = sel;
        bus.dport_req   = 1'b1;
      end else begin
        bus.iport_addr  = base + 32'(i * 4);
        bus.iport_req   = 1'b1;
      end
      while (!seen && w < 100) begin
        @(negedge clk);
        w++;
        seen = isData ? (bus.dport_ready | bus.dport_err) : (bus.iport_ready | bus.iport_err);
      end
      checkOutput(isData ? "dport_resp_seen" : "iport_resp_seen", 32'(seen), 32'h1);
    end
    if (isData) bus.dport_req = 1'b0;
    else        bus.iport_req = 1'b0;
  endtask

  // Single fetch with cycle-exact latency checks: bus active in the first
  // cycle after the sampling edge, ready in the second.
  task automatic fetchLatency(input logic [31:0] addr);
    bus.iport_addr = addr;
    bus.iport_req  = 1'b1;
    @(negedge clk);
    checkOutput("lat_cyc_first",   32'(bus.mem_cyc), 32'h1);
    checkOutput("lat_ready_first", 32'(bus.iport_ready), 32'h0);
    @(negedge clk);
    checkOutput("lat_ready_second", 32'(bus.iport_ready), 32'h1);
    checkOutput("lat_cyc_second",   32'(bus.mem_cyc), 32'h0);
    bus.iport_req = 1'b0;
  endtask

  // Bus slave: responds within the same cycle mem_cyc is seen (zero wait),
  // never, or with ack and err together, depending on slaveMode.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_err   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_cyc && slaveMode != SL_NONE) begin
        bus.mem_ack   = 1'b1;
        bus.mem_err   = (slaveMode == SL_BOTH);
        bus.mem_rdata = slaveData;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_err   = 1'b0;
      end
    end
  end

  // Bus monitor: every new bus cycle must match the next expected transaction.
  always @(negedge clk) begin : busMon
    bus_t want;
    if (rst) begin
      prevCyc = 1'b0;
    end else begin
      if (bus.mem_cyc && !prevCyc) begin
        checkOutput("bus_stb_eq_cyc", 32'(bus.mem_stb), 32'h1);
        if (busQ.size() == 0) begin
          checkOutput("bus_unexpected_cycle", bus.mem_addr, 32'hFFFF_FFFF);
        end else begin
          want = busQ.pop_front();
          checkOutput("bus_addr",  bus.mem_addr, want.addr);
          checkOutput("bus_wdata", bus.mem_wdata, want.wdata);
          checkOutput("bus_we",    32'(bus.mem_we), 32'(want.we));
          checkOutput("bus_sel",   32'(bus.mem_sel), 32'(want.sel));
        end
      end
      prevCyc = bus.mem_cyc;
    end
  end

  // Response monitor: every ready/err pulse must match the next expected
  // response, including the held data on error responses.
  always @(negedge clk) begin : respMon
    resp_t want;
    logic [3:0] pulses;
    if (!rst) begin
      pulses = {bus.iport_ready, bus.iport_err, bus.dport_ready, bus.dport_err};
      if (pulses != 4'b0) begin
        if (respQ.size() == 0) begin
          checkOutput("resp_unexpected", 32'(pulses), 32'h0);
        end else begin
          want = respQ.pop_front();
          checkOutput("resp_single_pulse", 32'($countones(pulses)), 32'h1);
          checkOutput("resp_port", 32'(bus.dport_ready | bus.dport_err), 32'(want.isData));
          checkOutput("resp_is_err", 32'(bus.iport_err | bus.dport_err), 32'(want.isErr));
          checkOutput("resp_data", want.isData ? bus.dport_rdata : bus.iport_data, want.data);
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    int cycCount;
    rst             = 1'b1;
    bus.iport_addr  = '0;
    bus.iport_req   = 1'b0;
    bus.dport_addr  = '0;
    bus.dport_wdata = '0;
    bus.dport_we    = 1'b0;
    bus.dport_sel   = '0;
    bus.dport_req   = 1'b0;

    repeat (2) @(negedge clk);
    #1 checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single fetch");
    slaveData = 32'h0000_0013;
    expectBus(32'h0000_0100, 32'h0, 1'b0, 4'hF);
    expectResp(1'b0, 1'b0, 32'h0000_0013);
    fetchLatency(32'h0000_0100);
    repeat (2) @(negedge clk);

    $display("[TB] contention: data write first, then fetch");
    slaveData = 32'hCAFE_0001;
    expectBus(32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 4'hF);
    expectBus(32'h0000_0104, 32'h0, 1'b0, 4'hF);
    expectResp(1'b1, 1'b0, 32'hCAFE_0001);
    expectResp(1'b0, 1'b0, 32'hCAFE_0001);
    fork
      applyStimulus(1'b1, 1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 4'hF);
      applyStimulus(1'b0, 1, 32'h0000_0104, 32'h0, 1'b0, 4'h0);
    join
    repeat (2) @(negedge clk);

    // Expected order D D D D I D I: the second fetch must wait for one more
    // data grant because the I grant restarted the starvation count.
    $display("[TB] starvation");
    slaveData = 32'h0BAD_F00D;
    expectBus(32'h0000_3000, 32'h0, 1'b0, 4'h3);
    expectBus(32'h0000_3004, 32'h0, 1'b0, 4'h3);
    expectBus(32'h0000_3008, 32'h0, 1'b0, 4'h3);
    expectBus(32'h0000_300C, 32'h0, 1'b0, 4'h3);
    expectBus(32'h0000_0108, 32'h0, 1'b0, 4'hF);
    expectBus(32'h0000_3010, 32'h0, 1'b0, 4'h3);
    expectBus(32'h0000_010C, 32'h0, 1'b0, 4'hF);
    for (int i = 0; i < 4; i++) expectResp(1'b1, 1'b0, 32'h0BAD_F00D);
    expectResp(1'b0, 1'b0, 32'h0BAD_F00D);
    expectResp(1'b1, 1'b0, 32'h0BAD_F00D);
    expectResp(1'b0, 1'b0, 32'h0BAD_F00D);
    fork
      applyStimulus(1'b1, 5, 32'h0000_3000, 32'h0, 1'b0, 4'h3);
      applyStimulus(1'b0, 2, 32'h0000_0108, 32'h0, 1'b0, 4'h0);
    join
    repeat (2) @(negedge clk);

    $display("[TB] timeout");
    slaveMode = SL_NONE;
    expectBus(32'h0000_0200, 32'h0, 1'b0, 4'hF);
    expectResp(1'b0, 1'b1, 32'h0BAD_F00D);
    bus.iport_addr = 32'h0000_0200;
    bus.iport_req  = 1'b1;
    cycCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_cyc) cycCount++;
      if (bus.iport_err || bus.iport_ready) break;
    end
    checkOutput("timeout_cyc_cycles", 32'(cycCount), 32'd8);
    bus.iport_req = 1'b0;
    slaveMode = SL_ACK;
    @(negedge clk);
    slaveData = 32'h0000_0093;
    expectBus(32'h0000_0204, 32'h0, 1'b0, 4'hF);
    expectResp(1'b0, 1'b0, 32'h0000_0093);
    fetchLatency(32'h0000_0204);
    repeat (2) @(negedge clk);

    $display("[TB] ack and err together");
    slaveMode = SL_BOTH;
    slaveData = 32'hFFFF_FFFF;
    expectBus(32'h0000_0500, 32'h0, 1'b0, 4'hF);
    expectResp(1'b1, 1'b1, 32'h0BAD_F00D);
    applyStimulus(1'b1, 1, 32'h0000_0500, 32'h0, 1'b0, 4'hF);
    slaveMode = SL_ACK;
    repeat (2) @(negedge clk);

    $display("[TB] reset during data transaction");
    slaveMode = SL_NONE;
    expectBus(32'h0000_0600, 32'h1234_5678, 1'b1, 4'hC);
    bus.dport_addr  = 32'h0000_0600;
    bus.dport_wdata = 32'h1234_5678;
    bus.dport_we    = 1'b1;
    bus.dport_sel   = 4'hC;
    bus.dport_req   = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_cyc", 32'(bus.mem_cyc), 32'h1);
    #2 rst = 1'b1;
    #1 checkAllZero("async_reset");
    @(negedge clk);
    bus.dport_req = 1'b0;
    bus.dport_we  = 1'b0;
    rst = 1'b0;
    slaveMode = SL_ACK;
    @(negedge clk);
    slaveData = 32'h0000_0067;
    expectBus(32'h0000_0208, 32'h0, 1'b0, 4'hF);
    expectResp(1'b0, 1'b0, 32'h0000_0067);
    fetchLatency(32'h0000_0208);

    repeat (3) @(negedge clk);
    checkOutput("resp_queue_drained", 32'(respQ.size()), 32'h0);
    checkOutput("bus_queue_drained", 32'(busQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory bus between the IF stage instruction port and the MEM stage data port of the Titan core.
- Grants requesters through an FSM: data has priority, with an instruction anti-starvation limit.
- Drives a Wishbone-style master interface, returns read data, ready and error to the granted requester, and aborts hung transactions with a timeout.

Parameters:
- TIMEOUT, 255: cycles with mem_cyc high and no ack/err before the transaction is aborted with err.
- STARVE_LIMIT, 4: consecutive data grants allowed while iport_req is pending; the next contended grant goes to instruction.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- iport_addr  in  32  instruction fetch address (pc)
- iport_req  in  1  fetch request; held until iport_ready or iport_err
- iport_data  out  32  fetched instruction, valid with iport_ready
- iport_ready  out  1  one-cycle completion pulse
- iport_err  out  1  one-cycle bus error/timeout pulse
- dport_addr  in  32  data address
- dport_wdata  in  32  store data
- dport_we  in  1  1 = write
- dport_sel  in  4  byte lane enables
- dport_req  in  1  data request; held until dport_ready or dport_err
- dport_rdata  out  32  load data, valid with dport_ready
- dport_ready  out  1  one-cycle completion pulse
- dport_err  out  1  one-cycle error pulse
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_we  out  1  bus write enable
- mem_sel  out  4  bus byte selects
- mem_cyc  out  1  bus cycle active
- mem_stb  out  1  bus strobe (equals mem_cyc)
- mem_rdata  in  32  bus read data
- mem_ack  in  1  bus acknowledge
- mem_err  in  1  bus error

Behaviour:
- All outputs are registered.
- Reset (async, any time including mid-transaction): every output goes to 0, FSM goes to IDLE, timeout and starve counters clear. No response is delivered for the aborted transaction.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Samples both requests.
  - dport_req only -> BUSY_D.
  - iport_req only -> BUSY_I.
  - Both -> BUSY_I if starve_cnt == STARVE_LIMIT, else BUSY_D.
  - On the transition, latch addr/wdata/we/sel of the winner onto mem_*; set mem_cyc = mem_stb = 1.
  - For an instruction grant: mem_we = 0, mem_sel = 4'hF, mem_wdata = 0.
- BUSY_x:
  - Holds mem_* stable; the timeout counter increments each cycle.
  - On mem_err, or on timeout count == TIMEOUT-1 without ack: drop cyc/stb, pulse x_err next cycle, -> RESP.
  - On mem_ack: capture mem_rdata into x_data/x_rdata, drop cyc/stb, pulse x_ready, -> RESP.
  - mem_ack and mem_err in the same cycle: err wins, data is not updated.
- RESP: ready/err high for exactly this cycle; -> IDLE next cycle. Requests are not sampled in RESP, so the requester must drop or replace req at the edge ending RESP.
- Minimum latency: req sampled at edge k, mem_cyc high from cycle k+1, zero-wait ack in k+1, ready high in cycle k+2. Turnaround: at least one cycle with mem_cyc = 0 between transactions.
- Req deassertion mid-BUSY is ignored; the transaction completes and its response is still pulsed.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - +1 on each data grant while iport_req = 1.
  - Cleared on an instruction grant, or on a data grant with iport_req = 0.
  - Saturates at STARVE_LIMIT.
- x_data/x_rdata hold their last value between responses.
- mem_addr is passed through unmodified; no alignment check.

Decomposition:
- Shared defines file: FSM state encodings (2-bit), bus width constants (XLEN = 32, SEL_W = 4).
- One sub-module, bus_timeout_counter:
  - inputs clk, rst, clear, enable
  - output expired
  - parameter TIMEOUT
- Arbitration and FSM stay in the top module.

Test Plan:
- Single fetch: iport_req = 1, iport_addr = 32'h0000_0100, slave acks first cycle with 32'h0000_0013 -> mem_cyc high 1 cycle, iport_ready pulse 2 cycles after req, iport_data = 32'h0000_0013.
- Contention: both req at once, dport write addr 32'h0000_2000, wdata 32'hDEAD_BEEF, sel 4'hF -> data served first (mem_we = 1), then fetch; one mem_cyc = 0 cycle between them.
- Starvation (STARVE_LIMIT = 4): dport_req and iport_req held high -> grant order D, D, D, D, I, D...; starve_cnt back to 0 after the I grant.
- Timeout (TIMEOUT = 8): fetch with no mem_ack -> mem_cyc drops after 8 cycles, iport_err pulse 1 cycle, iport_ready stays 0; next request is serviced normally.
- ack + err together on a data read -> dport_err = 1, dport_ready = 0, dport_rdata unchanged.
- rst asserted mid-BUSY_D -> all outputs 0 immediately (async); after release an iport_req is served with normal 2-cycle latency.
